// File: rtl/mem_io_capture.sv
// Passive snooper: queues CPU stores that hit the memory-mapped I/O window and drains them over valid/ready.
// Optional IO_CAPTURE_TS_EN adds a per-entry 16-bit capture timestamp on out_ts.
module mem_io_capture #(
   parameter logic [7:0] IO_BASE = 8'hF0,
   parameter int         IO_SIZE = 16,
   parameter int         DEPTH   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_rw,
   input  logic [7:0]               mem_addr,
   input  logic [15:0]              mem_d,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_addr,
   output logic [15:0]              out_data,
`ifdef IO_CAPTURE_TS_EN
   output logic [15:0]              out_ts,
`endif
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_cnt,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
`ifdef IO_CAPTURE_TS_EN
   localparam int EW = 40;
`else
   localparam int EW = 24;
`endif
   // Window bounds kept wider than the address so the end can sit past 8'hFF without wrapping.
   localparam logic [9:0] WIN_LO = {2'b00, IO_BASE};
   localparam logic [9:0] WIN_HI = 10'(int'(IO_BASE) + IO_SIZE);

   logic [EW-1:0] fifo_mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          mem_rw_q;
   logic [9:0]    addr_ext;
   logic          in_window;
   logic          capture;
   logic          full;
   logic          pop;
   logic          wr_en;
   logic          drop;
   logic [EW-1:0] entry;
   logic [EW-1:0] head;

   assign addr_ext  = {2'b00, mem_addr};
   assign in_window = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
   assign capture   = mem_rw && !mem_rw_q && in_window;

   assign level     = wr_ptr - rd_ptr;
   assign full      = (level == (AW+1)'(DEPTH));
   assign out_valid = (level != '0);
   assign pop       = out_valid && out_ready;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign wr_en     = capture && (!full || pop);
   assign drop      = capture && full && !pop;

`ifdef IO_CAPTURE_TS_EN
   logic [15:0] ts_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ts_cnt <= 16'h0000;
      else      ts_cnt <= ts_cnt + 16'h0001;
   end

   assign entry  = {ts_cnt, mem_addr, mem_d};
   assign out_ts = out_valid ? head[39:24] : 16'h0000;
`else
   assign entry  = {mem_addr, mem_d};
`endif

   assign head     = fifo_mem[rd_ptr[AW-1:0]];
   assign out_addr = out_valid ? head[23:16] : 8'h00;
   assign out_data = out_valid ? head[15:0]  : 16'h0000;

   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_ptr[AW-1:0]] <= entry;
   end

   // mem_rw_q resets high so a store already in progress at release is not captured.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_rw_q <= 1'b1;
      end else begin
         mem_rw_q <= mem_rw;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
         drop_cnt <= 8'h00;
      end else if (clr_ovf) begin
         overflow <= drop;
         drop_cnt <= drop ? 8'h01 : 8'h00;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
      end
   end

endmodule

// File: tb/tb_mem_io_capture.sv
// Scoreboard bench for mem_io_capture: captures pushed on drive, compared as the consumer pops them.
module tb_mem_io_capture;

   localparam int DEPTH = 8;

   logic        clk;
   logic        rst;
   logic        mem_rw;
   logic [7:0]  mem_addr;
   logic [15:0] mem_d;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_addr;
   logic [15:0] out_data;
`ifdef IO_CAPTURE_TS_EN
   logic [15:0] out_ts;
`endif
   logic [3:0]  level;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        clr_ovf;

   int total = 0;
   int bad   = 0;
   int model_drops = 0;
   logic [23:0] sb_q [$];

   mem_io_capture #(.IO_BASE(8'hF0), .IO_SIZE(16), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_rw    (mem_rw),
      .mem_addr  (mem_addr),
      .mem_d     (mem_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
`ifdef IO_CAPTURE_TS_EN
      .out_ts    (out_ts),
`endif
      .level     (level),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .clr_ovf   (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // Pop side of the scoreboard: a handshake visible mid-cycle completes at the next rising edge.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected: got addr=%h data=%h, required no valid entry", out_addr, out_data);
         end else begin
            logic [23:0] exp;
            exp = sb_q.pop_front();
            if ({out_addr, out_data} !== exp) begin
               bad++;
               $display("FAIL pop_entry: got addr=%h data=%h, required addr=%h data=%h",
                        out_addr, out_data, exp[23:16], exp[15:0]);
            end
         end
      end
   end

   // One store: mem_rw high for one cycle then low for one; the model decides keep/drop.
   task automatic store(input logic [7:0] a, input logic [15:0] d, input logic rdy, input logic clr);
      logic will_pop;
      mem_rw    = 1'b1;
      mem_addr  = a;
      mem_d     = d;
      out_ready = rdy;
      clr_ovf   = clr;
      will_pop  = rdy && (sb_q.size() > 0);
      if (clr) model_drops = 0;
      if (a >= 8'hF0) begin
         if (sb_q.size() < DEPTH || will_pop) sb_q.push_back({a, d});
         else model_drops++;
      end
      @(posedge clk); #1;
      mem_rw    = 1'b0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (sb_q.size() > 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (sb_q.size() != 0 || level !== 4'd0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain: queue_left=%0d level=%0d valid=%b, required 0 0 0", sb_q.size(), level, out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_rw = 1'b0; mem_addr = 8'h00; mem_d = 16'h0000;
      out_ready = 1'b0; clr_ovf = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || level !== 4'd0 || out_addr !== 8'h00 || out_data !== 16'h0000) begin
         bad++;
         $display("FAIL reset_fifo: valid=%b level=%0d addr=%h data=%h, required 0 0 00 0000",
                  out_valid, level, out_addr, out_data);
      end
      total++;
      if (overflow !== 1'b0 || drop_cnt !== 8'h00) begin
         bad++;
         $display("FAIL reset_status: ovf=%b drop=%h, required 0 00", overflow, drop_cnt);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      store(8'hF3, 16'h1234, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || out_addr !== 8'hF3 || out_data !== 16'h1234 || level !== 4'd1) begin
         bad++;
         $display("FAIL single: valid=%b addr=%h data=%h level=%0d, required 1 f3 1234 1",
                  out_valid, out_addr, out_data, level);
      end
      drain();
   endtask

   task automatic test_filter();
      store(8'hEF, 16'hAAAA, 1'b0, 1'b0);
      store(8'h00, 16'hBBBB, 1'b0, 1'b0);
      mem_addr = 8'hF0; mem_d = 16'hCCCC;
      @(posedge clk); #1;
      total++;
      if (level !== 4'd0) begin
         bad++;
         $display("FAIL filter_read: level=%0d, required 0", level);
      end
      mem_rw = 1'b1;
      sb_q.push_back({8'hF0, 16'hCCCC});
      repeat (3) @(posedge clk);
      #1;
      mem_rw = 1'b0;
      @(posedge clk); #1;
      total++;
      if (level !== 4'd1 || out_addr !== 8'hF0) begin
         bad++;
         $display("FAIL filter_held: level=%0d addr=%h, required 1 f0", level, out_addr);
      end
      store(8'hFF, 16'h0FF0, 1'b0, 1'b0);
      total++;
      if (level !== 4'd2) begin
         bad++;
         $display("FAIL window_top: level=%0d, required 2", level);
      end
      drain();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 9; i++) store(8'hF0 + 8'(i), 16'h1000 + 16'(i), 1'b0, 1'b0);
      total++;
      if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
         bad++;
         $display("FAIL overflow: level=%0d ovf=%b drop=%0d, required 8 1 1", level, overflow, drop_cnt);
      end
      store(8'hF1, 16'hF1F1, 1'b1, 1'b0);
      total++;
      if (level !== 4'd8 || drop_cnt !== 8'd1) begin
         bad++;
         $display("FAIL full_pop_store: level=%0d drop=%0d, required 8 1", level, drop_cnt);
      end
      drain();
   endtask

   task automatic test_clear();
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      model_drops = 0;
      total++;
      if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
         bad++;
         $display("FAIL clear_alone: ovf=%b drop=%0d, required 0 0", overflow, drop_cnt);
      end
      for (int i = 0; i < 13; i++) store(8'hF4, 16'h2000 + 16'(i), 1'b0, 1'b0);
      total++;
      if (overflow !== 1'b1 || drop_cnt !== 8'd5) begin
         bad++;
         $display("FAIL drops5: ovf=%b drop=%0d, required 1 5", overflow, drop_cnt);
      end
      store(8'hF5, 16'h5555, 1'b0, 1'b1);
      total++;
      if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
         bad++;
         $display("FAIL clear_with_drop: ovf=%b drop=%0d, required 1 1", overflow, drop_cnt);
      end
      for (int i = 0; i < 256; i++) store(8'hF6, 16'h3000 + 16'(i), 1'b0, 1'b0);
      total++;
      if (drop_cnt !== 8'hFF) begin
         bad++;
         $display("FAIL drop_saturate: drop=%h, required ff", drop_cnt);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) store(8'hF8 + 8'(i), 16'h4000 + 16'(i), 1'b0, 1'b0);
      total++;
      if (level !== 4'd4) begin
         bad++;
         $display("FAIL pre_reset_level: level=%0d, required 4", level);
      end
      #2;
      rst = 1'b0;
      #1;
      sb_q.delete();
      model_drops = 0;
      total++;
      if (out_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: valid=%b level=%0d ovf=%b, required 0 0 0", out_valid, level, overflow);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      store(8'hFA, 16'hBEEF, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || out_addr !== 8'hFA || out_data !== 16'hBEEF || level !== 4'd1) begin
         bad++;
         $display("FAIL after_reset: valid=%b addr=%h data=%h level=%0d, required 1 fa beef 1",
                  out_valid, out_addr, out_data, level);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++)
         store(8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 8'hEF) : $urandom_range(8'hF0, 8'hFF)),
               16'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0);
      total++;
      if (drop_cnt !== 8'(model_drops) || overflow !== (model_drops != 0)) begin
         bad++;
         $display("FAIL random_drops: ovf=%b drop=%0d, required %b %0d",
                  overflow, drop_cnt, model_drops != 0, model_drops);
      end
      total++;
      if (level !== 4'(sb_q.size())) begin
         bad++;
         $display("FAIL random_level: level=%0d, required %0d", level, sb_q.size());
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_filter();
      test_overflow();
      test_clear();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
